serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial unsigned subtractor that computes `a - b` one bit per clock. It uses a single `full_sub` cell as its datapath and keeps the borrow in a register between bits. It sits directly downstream of the combinational full subtractor and turns it into a multi-bit sequential unit for area-constrained paths. Operands load in parallel, are processed LSB first, and the result is presented in parallel with a one-cycle completion pulse.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range `WIDTH >= 2`.
- `clk_in`  input  1  clock; all state updates on the rising edge.
- `rst_n_in`  input  1  asynchronous, active-low reset.
- `start_in`  input  1  request to load the operands and begin; sampled only in IDLE.
- `a_in`  input  WIDTH  minuend; sampled on the accepted start edge.
- `b_in`  input  WIDTH  subtrahend; sampled on the accepted start edge.
- `busy_out`  output  1  high while in RUN.
- `done_out`  output  1  one-cycle pulse; the result outputs are valid from this cycle on.
- `diff_out`  output  WIDTH  `(a - b) mod 2^WIDTH` of the last completed operation.
- `borrow_out`  output  1  final borrow of the last completed operation; 1 iff `a < b` (unsigned).

## Operation
- FSM states:
  - IDLE: waits for `start_in`.
  - RUN: processes one bit per clock.
  - DONE: lasts one cycle, then returns to IDLE.
- IDLE, with `start_in=1` at an edge:
  - load the A and B shift registers from `a_in` and `b_in`;
  - clear the borrow register and the bit counter;
  - go to RUN.
- RUN, on each edge:
  - The `full_sub` cell is fed `a_sr[0]`, `b_sr[0]` and `borrow_q`.
  - The A and B shift registers shift right by one.
  - The cell's difference bit shifts into the MSB of the partial-result register, which also shifts right.
  - `borrow_q` takes the cell's borrow; the counter increments.
- RUN to DONE: on the edge where the counter reaches `WIDTH-1`, after the final bit is processed.
- The same DONE-entry edge copies the partial result into `diff_out` and the final borrow into `borrow_out`.
- DONE: `done_out=1` for exactly one cycle; unconditional transition to IDLE.
- `start_in` in RUN or DONE is ignored. It is not queued, and the operands are not resampled.
- `diff_out` and `borrow_out` hold their values until the next completion. A new start does not disturb them.
- Arithmetic:
  - per-bit `d = a ^ b ^ c`;
  - per-bit `borrow = (~a & c) | (~a & b) | (b & c)`;
  - the initial borrow is 0.
- Counter width is `$clog2(WIDTH)`, with a minimum of 1. The counter never wraps in normal operation because it is cleared on load.

## Timing
- Reset values: state IDLE, `busy_out=0`, `done_out=0`, `diff_out=0`, `borrow_out=0`. All shift registers, `borrow_q` and the counter are 0.
- Reset is asynchronous: outputs go to their reset values immediately, without waiting for a clock edge.
- Reset asserted mid-RUN aborts the operation. No `done_out` is produced and the previous result is cleared.
- Latency:
  - start accepted at edge E0;
  - RUN from E0 through E(WIDTH);
  - `done_out` high in the cycle after edge E(WIDTH);
  - i.e. WIDTH clocks of RUN, and `done_out` WIDTH cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously is accepted on the first IDLE edge after DONE.
- `busy_out` is registered and rises the cycle after E0. It falls in the same cycle that `done_out` rises.
- No combinational path from any input to any output.

## Structure
- Shared package `serial_sub_pkg`: FSM state encodings (`S_IDLE`, `S_RUN`, `S_DONE`, 2-bit binary) and the default width constant.
- Sub-module: one `full_sub` instance as the bit cell. The surrounding registers, counter and FSM live in `serial_sub`.
- The cell's debug outputs (`a_not_out`, etc.) are left unconnected.

## Test plan
All scenarios use WIDTH=8.
- `a=0x05, b=0x03`, start -> `done_out` exactly 8 cycles after acceptance; `diff_out=0x02`, `borrow_out=0`.
- `a=0x03, b=0x05` -> `diff_out=0xFE`, `borrow_out=1`. Then `a=0x00, b=0xFF` -> `diff_out=0x01`, `borrow_out=1`.
- `a=0xFF, b=0xFF` -> `diff_out=0x00`, `borrow_out=0`. `busy_out` is high for exactly 8 cycles and `done_out` for exactly 1 cycle.
- Start with `a=0x10, b=0x01`; at RUN cycle 3, pulse `start_in` with `a=0x00, b=0x01` -> the second start is ignored, with a single `done_out` and `diff_out=0x0F`.
- Start with `a=0x80, b=0x01`; deassert `rst_n_in` at RUN cycle 4 -> all outputs are 0 immediately, there is no `done_out`, and the FSM is in IDLE after release.
- Hold `start_in=1` with random operands for 5 operations -> back-to-back results match the golden model, with a 10-cycle period between `done_out` pulses.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Bit counter width, never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result bundle between a requester and serial_sub.
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;

    modport master (
        output start_in, a_in, b_in,
        input  busy_out, done_out, diff_out, borrow_out
    );

    modport slave (
        input  start_in, a_in, b_in,
        output busy_out, done_out, diff_out, borrow_out
    );
endinterface

// File: rtl/serial_sub_full_sub.sv
// Combinational one-bit full subtractor: a - b - c.
module full_sub (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic d_out,
    output logic borrow_out,
    output logic a_not_out
);
    assign a_not_out  = ~a_in;
    assign d_out      = a_in ^ b_in ^ c_in;
    assign borrow_out = (a_not_out & c_in) | (a_not_out & b_in) | (b_in & c_in);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full_sub cell, borrow held between bits, LSB first.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    serial_sub_if.slave  bus
);
    localparam int CW = cnt_w(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow_q;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic             w_d;
    logic             w_b;

    full_sub u_cell (
        .a_in       (r_a_sr[0]),
        .b_in       (r_b_sr[0]),
        .c_in       (r_borrow_q),
        .d_out      (w_d),
        .borrow_out (w_b),
        .a_not_out  ()
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_res      <= '0;
            r_diff     <= '0;
            r_cnt      <= '0;
            r_borrow_q <= 1'b0;
            r_borrow   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start_in) begin
                        r_a_sr     <= bus.a_in;
                        r_b_sr     <= bus.b_in;
                        r_borrow_q <= 1'b0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr     <= r_a_sr >> 1;
                    r_b_sr     <= r_b_sr >> 1;
                    r_res      <= {w_d, r_res[WIDTH-1:1]};
                    r_borrow_q <= w_b;
                    r_cnt      <= r_cnt + 1'b1;
                    // Last bit: publish the result including this cycle's cell output.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_diff   <= {w_d, r_res[WIDTH-1:1]};
                        r_borrow <= w_b;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_out   = r_busy;
    assign bus.done_out   = r_done;
    assign bus.diff_out   = r_diff;
    assign bus.borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub with a queue of expected results.
module tb_serial_sub;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [W:0] exp_q [$];

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        return {(a < b), d};
    endfunction

    // Advance edge by edge until done_out; n = edges waited, bc = busy samples seen.
    task automatic wait_done(output int n, output int bc);
        n = 0; bc = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (bus.busy_out) bc++;
        end while (!bus.done_out && n < 40);
        if (!bus.done_out) chk("timeout", 32'(n), 32'd0);
    endtask

    task automatic check_result(input string tag);
        logic [W:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_diff"}, 32'(bus.diff_out), 32'(e[W-1:0]));
            chk({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e[W]));
        end
    endtask

    // Drive one start for a single cycle; returns right after the accepting edge (+1).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start_in = 1'b1; bus.a_in = a; bus.b_in = b;
        exp_q.push_back(golden(a, b));
        @(posedge clk); #1;
        bus.start_in = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit check_timing);
        int n, bc, b0;
        launch(a, b);
        b0 = bus.busy_out ? 1 : 0;
        wait_done(n, bc);
        if (check_timing) begin
            chk({tag, "_lat"}, 32'(n), 32'(W));
            chk({tag, "_busycyc"}, 32'(b0 + bc), 32'(W));
        end
        check_result(tag);
        @(posedge clk); #1;
        if (check_timing) chk({tag, "_donewidth"}, 32'(bus.done_out), 32'd0);
    endtask

    initial begin
        int n, bc, dcount;
        logic [W-1:0] ra, rb;
        bus.start_in = 1'b0; bus.a_in = '0; bus.b_in = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy_out), 32'd0);
        chk("rst_done", 32'(bus.done_out), 32'd0);
        chk("rst_diff", 32'(bus.diff_out), 32'd0);
        chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("s5m3", 8'h05, 8'h03, 1'b1);
        run_op("s3m5", 8'h03, 8'h05, 1'b0);
        run_op("s0mff", 8'h00, 8'hFF, 1'b0);
        run_op("sffmff", 8'hFF, 8'hFF, 1'b1);

        // Second start mid-run must be ignored.
        launch(8'h10, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        bus.start_in = 1'b1; bus.a_in = 8'h00; bus.b_in = 8'h01;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done_out) begin
                dcount++;
                if (dcount == 1) check_result("ign");
            end
            @(posedge clk); #1;
        end
        chk("ign_donecount", 32'(dcount), 32'd1);
        chk("ign_hold_diff", 32'(bus.diff_out), 32'h0F);

        // Reset mid-run: immediate clear, no completion.
        launch(8'h80, 8'h01);
        void'(exp_q.pop_back());
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy_out), 32'd0);
        chk("arst_done", 32'(bus.done_out), 32'd0);
        chk("arst_diff", 32'(bus.diff_out), 32'd0);
        chk("arst_borrow", 32'(bus.borrow_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done_out || bus.busy_out) dcount++;
        end
        chk("arst_nodone", 32'(dcount), 32'd0);
        run_op("post_rst", 8'h03, 8'h05, 1'b1);

        // Held start: back-to-back operations, period W+2.
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom);
        bus.start_in = 1'b1; bus.a_in = ra; bus.b_in = rb;
        exp_q.push_back(golden(ra, rb));
        for (int k = 0; k < 5; k++) begin
            wait_done(n, bc);
            if (k > 0) chk($sformatf("b2b%0d_period", k), 32'(n), 32'(W + 2));
            check_result($sformatf("b2b%0d", k));
            if (k < 4) begin
                ra = 8'($urandom); rb = 8'($urandom);
                bus.a_in = ra; bus.b_in = rb;
                exp_q.push_back(golden(ra, rb));
            end
        end
        bus.start_in = 1'b0;
        chk("q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
